// File: rtl/bp_cce_mem_responder.sv
// bp_cce_mem_responder
//   Memory-side responder for the CCE memory channel. Accepts one command at a
//   time, services it against a block-addressed backing array and returns the
//   response after a fixed latency.
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   mem_cmd_i / _v_i / _ready_o   command message, valid, ready
//   mem_resp_o / _v_o / _yumi_i   response message, valid, consumer take
// Message packing (LSB->MSB): msg_type[3:0], addr, size[2:0], payload, data.
module bp_cce_mem_responder #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned block_width_p   = 512,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned mem_els_p       = 256,
  parameter int unsigned latency_p       = 4,
  localparam int unsigned mw_lp = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [mw_lp-1:0] mem_cmd_i,
  input  logic             mem_cmd_v_i,
  output logic             mem_cmd_ready_o,
  output logic [mw_lp-1:0] mem_resp_o,
  output logic             mem_resp_v_o,
  input  logic             mem_resp_yumi_i
);

  localparam int unsigned bytes_lp    = block_width_p / 8;
  localparam int unsigned off_lp      = $clog2(bytes_lp);
  localparam int unsigned idx_w_lp    = $clog2(mem_els_p);
  localparam int unsigned cnt_w_lp    = (latency_p < 1) ? 1 : $clog2(latency_p + 1);
  localparam int unsigned addr_lsb_lp = 4;
  localparam int unsigned size_lsb_lp = addr_lsb_lp + paddr_width_p;
  localparam int unsigned data_lsb_lp = size_lsb_lp + 3 + payload_width_p;
  localparam logic [2:0]  off_sz_lp   = 3'(off_lp);

  typedef enum logic [1:0] {e_reset, e_idle, e_wait, e_resp} state_e;
  typedef enum logic [3:0] {e_rd = 4'd0, e_wr = 4'd1, e_uc_rd = 4'd2, e_uc_wr = 4'd3} msg_type_e;

  state_e                     state_q, state_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic [mw_lp-1:0]           cmd_q, cmd_d;
  logic [mw_lp-1:0]           resp_q, resp_d;
  logic [block_width_p-1:0]   mem_q [mem_els_p];

  logic [mw_lp-1:0]           cmd_s;
  logic [3:0]                 c_type;
  logic [2:0]                 c_size;
  logic [block_width_p-1:0]   c_data;
  logic [off_lp-1:0]          c_off;
  logic [idx_w_lp-1:0]        idx;
  logic [block_width_p-1:0]   rd_blk;
  logic [2:0]                 eff_size;
  logic [off_lp-1:0]          byte_off;
  int unsigned                byte_off_i, n_bytes;
  logic [block_width_p-1:0]   wr_shift, rd_shift, uc_merge, uc_rdata;
  logic [block_width_p-1:0]   resp_data, mem_wdata;
  logic                       is_wr, do_access, mem_we;

  // With zero latency the access happens on the accept edge itself, so the
  // command is taken straight from the input rather than from cmd_q.
  assign cmd_s  = (state_q == e_idle) ? mem_cmd_i : cmd_q;
  assign c_type = cmd_s[3:0];
  assign c_size = cmd_s[size_lsb_lp +: 3];
  assign c_data = cmd_s[data_lsb_lp +: block_width_p];
  assign c_off  = cmd_s[addr_lsb_lp +: off_lp];
  assign idx    = cmd_s[addr_lsb_lp + off_lp +: idx_w_lp];
  assign rd_blk = mem_q[idx];

  always_comb begin
    eff_size   = (c_size > off_sz_lp) ? off_sz_lp : c_size;
    byte_off   = c_off & ({off_lp{1'b1}} << eff_size);
    byte_off_i = 32'(byte_off);
    n_bytes    = 32'd1 << eff_size;
    wr_shift   = c_data << {byte_off, 3'b000};
    rd_shift   = rd_blk >> {byte_off, 3'b000};
    uc_merge   = '0;
    uc_rdata   = '0;
    for (int unsigned i = 0; i < bytes_lp; i++) begin
      uc_merge[8*i +: 8] = ((i >= byte_off_i) && (i < byte_off_i + n_bytes))
                           ? wr_shift[8*i +: 8] : rd_blk[8*i +: 8];
      uc_rdata[8*i +: 8] = (i < n_bytes) ? rd_shift[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    resp_data = '0;
    mem_wdata = '0;
    is_wr     = 1'b0;
    case (c_type)
      e_rd:    resp_data = rd_blk;
      e_uc_rd: resp_data = uc_rdata;
      e_wr:    begin mem_wdata = c_data;   is_wr = 1'b1; end
      e_uc_wr: begin mem_wdata = uc_merge; is_wr = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    do_access = 1'b0;
    case (state_q)
      e_reset: state_d = e_idle;
      e_idle: begin
        if (mem_cmd_v_i) begin
          cmd_d = mem_cmd_i;
          cnt_d = cnt_w_lp'(latency_p);
          if (latency_p == 0) begin
            state_d   = e_resp;
            do_access = 1'b1;
          end else begin
            state_d = e_wait;
          end
        end
      end
      // Counter holds latency_p after accept and leaves WAIT once it has
      // counted down to zero: RESP is entered latency_p+1 edges after accept.
      e_wait: begin
        if (cnt_q == '0) begin
          state_d   = e_resp;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      e_resp: if (mem_resp_yumi_i) state_d = e_idle;
      default: state_d = e_reset;
    endcase
    if (do_access) resp_d = {resp_data, cmd_s[data_lsb_lp-1:0]};
  end

  assign mem_we = do_access & is_wr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
      cnt_q   <= '0;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
    end
  end

  // Backing array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx] <= mem_wdata;
  end

  assign mem_cmd_ready_o = (state_q == e_idle);
  assign mem_resp_v_o    = (state_q == e_resp);
  assign mem_resp_o      = resp_q;

endmodule

// File: tb/tb_bp_cce_mem_responder.sv
module tb_bp_cce_mem_responder;
  localparam int unsigned MW = 4 + 40 + 3 + 16 + 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn0, rstn1;
  logic [MW-1:0] cmd0, cmd1, resp0, resp1;
  logic          v0, v1, rdy0, rdy1, rv0, rv1, y0, y1;

  bp_cce_mem_responder #(.paddr_width_p(40), .block_width_p(512), .payload_width_p(16),
                         .mem_els_p(256), .latency_p(4)) dut0 (
    .clk_i(clk), .reset_n_i(rstn0), .mem_cmd_i(cmd0), .mem_cmd_v_i(v0),
    .mem_cmd_ready_o(rdy0), .mem_resp_o(resp0), .mem_resp_v_o(rv0), .mem_resp_yumi_i(y0));

  bp_cce_mem_responder #(.paddr_width_p(40), .block_width_p(512), .payload_width_p(16),
                         .mem_els_p(256), .latency_p(0)) dut1 (
    .clk_i(clk), .reset_n_i(rstn1), .mem_cmd_i(cmd1), .mem_cmd_v_i(v1),
    .mem_cmd_ready_o(rdy1), .mem_resp_o(resp1), .mem_resp_v_o(rv1), .mem_resp_yumi_i(y1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [MW+1:0] obs, input logic [MW+1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: byte-addressed copy of each instance's backing array.
  logic [7:0] mdl [2][256][64];

  function automatic logic get_rdy(input bit sel); return sel ? rdy1 : rdy0; endfunction
  function automatic logic get_rv(input bit sel); return sel ? rv1 : rv0; endfunction
  function automatic logic [MW-1:0] get_resp(input bit sel); return sel ? resp1 : resp0; endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_op(input bit sel, input logic [3:0] t, input logic [39:0] a,
                          input logic [2:0] s, input logic [511:0] d, output logic [511:0] ed);
    int unsigned idx, off, n, base;
    idx  = int'((a >> 6) % 256);
    off  = int'(a % 64);
    n    = 1 << ((s > 3'd6) ? 6 : int'(s));
    base = (off / n) * n;
    ed   = '0;
    case (t)
      4'd0: for (int k = 0; k < 64; k++) ed[8*k +: 8] = mdl[sel][idx][k];
      4'd1: for (int k = 0; k < 64; k++) mdl[sel][idx][k] = d[8*k +: 8];
      4'd2: for (int k = 0; k < n; k++) ed[8*k +: 8] = mdl[sel][idx][base + k];
      4'd3: for (int k = 0; k < n; k++) mdl[sel][idx][base + k] = d[8*k +: 8];
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at a negedge with the response consumed.
  task automatic xact(input bit sel, input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                      input logic [15:0] p, input logic [511:0] d, input int hold);
    logic [511:0]  ed;
    logic [MW-1:0] exp;
    int w, lat, exp_lat;
    w = 0;
    while (get_rdy(sel) !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("rdy_wait", get_rdy(sel), 1);
    if (sel) begin cmd1 = {d, p, s, a, t}; v1 = 1'b1; end
    else     begin cmd0 = {d, p, s, a, t}; v0 = 1'b1; end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    model_op(sel, t, a, s, d, ed);
    exp     = {ed, p, s, a, t};
    exp_lat = sel ? 1 : 6;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) chk("busy_rdy", get_rdy(sel), 0);
    end while (get_rv(sel) !== 1'b1 && lat < 40);
    chk("latency", lat, exp_lat);
    chk("resp", get_resp(sel), exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold", {get_rv(sel), get_rdy(sel), get_resp(sel)}, {1'b1, 1'b0, exp});
    end
    if (sel) y1 = 1'b1; else y0 = 1'b1;
    @(posedge clk); #1;
    y0 = 1'b0; y1 = 1'b0;
    @(negedge clk);
    chk("post_yumi", {get_rdy(sel), get_rv(sel)}, 2'b10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [511:0] pat_a, pat_b, pat_c;
  logic [39:0]  ra;
  logic [3:0]   rt;
  int unsigned  pool [6] = '{2, 3, 7, 64, 128, 255};
  int           cnt, r;

  initial begin
    rstn0 = 1'b1; rstn1 = 1'b1;
    cmd0 = '0; cmd1 = '0; v0 = 1'b0; v1 = 1'b0; y0 = 1'b0; y1 = 1'b0;
    #3 rstn0 = 1'b0; rstn1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0", {rv0, rdy0, resp0}, '0);
    chk("reset1", {rv1, rdy1, resp1}, '0);
    rstn0 = 1'b1; rstn1 = 1'b1;
    #1;
    chk("rel_rdy_lo", {rdy0, rdy1}, 2'b00);
    @(negedge clk);
    chk("rel_rdy_hi", {rdy0, rdy1}, 2'b11);

    pat_a = rand_block();
    pat_b = rand_block();
    xact(0, 4'd1, 40'h80, 3'd6, 16'h1234, pat_a, 0);
    xact(0, 4'd0, 40'h80, 3'd6, 16'hBEEF, '0, 1);
    xact(0, 4'd3, 40'h85, 3'd0, 16'h0001, 512'hAB, 0);
    xact(0, 4'd2, 40'h80, 3'd3, 16'h0002, '0, 0);
    xact(0, 4'd2, 40'h85, 3'd0, 16'h0003, '0, 0);
    xact(0, 4'd1, 40'h80 + 40'(256 * 64), 3'd6, 16'h0004, pat_b, 0);
    xact(0, 4'd0, 40'h80, 3'd6, 16'h0005, '0, 10);
    xact(0, 4'd9, 40'h80, 3'd2, 16'h0006, pat_a, 0);

    // Reset while the write is still waiting: the write must be lost.
    pat_c = rand_block();
    cmd0 = {pat_c, 16'h0BAD, 3'd6, 40'h80, 4'd1};
    v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (2) @(negedge clk);
    rstn0 = 1'b0;
    #1 chk("mid_reset", {rv0, rdy0, resp0}, '0);
    repeat (2) @(negedge clk);
    rstn0 = 1'b1;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (rv0 === 1'b1) cnt++; end
    chk("no_resp", cnt, 0);
    xact(0, 4'd0, 40'h80, 3'd6, 16'h0007, '0, 0);

    for (int sel = 0; sel < 2; sel++) begin
      foreach (pool[i]) begin
        ra = {26'($urandom), 8'(pool[i]), 6'($urandom)};
        xact(sel[0], 4'd1, ra, 3'($urandom), 16'($urandom), rand_block(), 0);
      end
      for (int n = 0; n < (sel == 0 ? 60 : 20); n++) begin
        r  = $urandom_range(0, 5);
        rt = (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
        ra = {26'($urandom), 8'(pool[$urandom_range(0, 5)]), 6'($urandom)};
        xact(sel[0], rt, ra, 3'($urandom), 16'($urandom), rand_block(), $urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
